// File: rtl/mux_4_1_rr.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_1_rr
// Purpose  : Four-channel round-robin stream merger with packet-level locking.
//            Each output beat carries the index of its source channel so a
//            downstream 1:4 demux can route it back. One registered output
//            stage sustains one beat per clock.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid[3:0]   - per-channel beat valid
//            in_last[3:0]    - per-channel end-of-packet marker
//            in_data         - channel i at [i*WIDTH +: WIDTH]
//            in_ready[3:0]   - per-channel accept (one-hot or zero)
//            out_valid/out_ready/out_data/out_last/out_sel - merged stream
// Revision : 1.0 - initial release
// ============================================================================
module mux_4_1_rr #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           in_valid,
    input  logic [3:0]           in_last,
    input  logic [4*WIDTH-1:0]   in_data,
    output logic [3:0]           in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_last,
    output logic [1:0]           out_sel
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [1:0]         r_owner;
    logic [1:0]         w_owner_nxt;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_last;
    logic [1:0]         r_out_sel;

    logic               w_load;
    logic [1:0]         w_srch_gnt;
    logic               w_srch_vld;
    logic [1:0]         w_gnt;
    logic               w_gnt_vld;
    logic               w_accept;
    logic               w_gnt_last;

    // Output stage can take a new beat when empty or when its beat drains now.
    assign w_load = ~r_out_valid | out_ready;

    // Rotating search: walk from the far end back towards r_ptr so the last
    // hit, i.e. the closest one to r_ptr, wins.
    always_comb begin
        logic [1:0] idx;
        w_srch_gnt = r_ptr;
        w_srch_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = r_ptr + 2'(k);
            if (in_valid[idx]) begin
                w_srch_gnt = idx;
                w_srch_vld = 1'b1;
            end
        end
    end

    // While a packet is open only its owner is eligible.
    always_comb begin
        w_gnt     = w_srch_gnt;
        w_gnt_vld = w_srch_vld;
        if (r_state == ST_LOCK) begin
            w_gnt     = r_owner;
            w_gnt_vld = in_valid[r_owner];
        end
    end

    assign w_accept   = w_gnt_vld & w_load & ~rst;
    assign w_gnt_last = in_last[w_gnt];
    assign in_ready   = w_accept ? (4'b0001 << w_gnt) : 4'b0000;

    // Next-state logic for the arbitration FSM, pointer and owner.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        if (w_accept) begin
            if (w_gnt_last) begin
                w_state_nxt = ST_ARB;
                w_ptr_nxt   = w_gnt + 2'd1;
            end else begin
                w_state_nxt = ST_LOCK;
                w_owner_nxt = w_gnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ARB;
            r_ptr   <= 2'd0;
            r_owner <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    // Output register: data/last/sel only change when a new beat is taken,
    // so they hold their last value while the stage is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= 2'd0;
        end else if (w_load) begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_data <= in_data[w_gnt*WIDTH +: WIDTH];
                r_out_last <= w_gnt_last;
                r_out_sel  <= w_gnt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: doc/mux_4_1_rr.md
# mux_4_1_rr

Four-channel round-robin stream merger: the gather-side counterpart of the 1:4 demultiplexer. It accepts packets from four valid/ready input channels, arbitrates between them with packet-level locking, and emits one merged stream. Each beat is tagged with its source index so a downstream 1:4 demux can route it back. A single registered output stage gives full throughput: one beat per clock.

## Interface
- WIDTH, 8, data bits per beat on every channel
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  4  per-channel beat valid; bit i is channel i
- in_last  input  4  per-channel end-of-packet marker, qualified by in_valid[i]
- in_data  input  4*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  4  per-channel accept; at most one bit is high in any cycle
- out_valid  output  1  out_data, out_last and out_sel are valid
- out_ready  input  1  downstream accept
- out_data  output  WIDTH  merged beat data
- out_last  output  1  end-of-packet for the current beat
- out_sel  output  2  source channel index of the current beat (demux select encoding)

## Operation
- Output register: out_valid/out_data/out_last/out_sel are registers. The load enable is load = ~out_valid | out_ready.
- Transfer rule: a beat moves on an input channel when in_valid[i] & in_ready[i]. It moves on the output when out_valid & out_ready.
- Rotation pointer ptr[1:0] gives the highest-priority channel. The search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- State ARB (no packet open):
  - grant = first channel in search order with in_valid set.
  - in_ready[grant] = load. All other in_ready bits are 0.
  - On an accepted beat, the output register loads in_data[grant], in_last[grant] and sel = grant.
  - If in_last[grant] = 1: stay in ARB and set ptr <= grant+1 (3 wraps to 0).
  - If in_last[grant] = 0: go to LOCK and set owner <= grant.
- State LOCK (packet open on owner):
  - Only the owner is eligible: in_ready[owner] = load. Other channels are held off even if valid.
  - An accepted beat with in_last = 1 sets ptr <= owner+1 and returns to ARB. An accepted beat with in_last = 0 keeps LOCK.
  - If the owner drops in_valid, the output simply idles. There is no timeout and no preemption.
- No valid input with load = 1: out_valid goes to 0 when the current beat is consumed. out_data/out_last/out_sel hold their previous values.
- out_ready = 0 with out_valid = 1: all output registers hold, and every in_ready bit is 0.
- Data is never dropped, duplicated or reordered within a channel. Packets from different channels never interleave on the output.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_last = 0, out_sel = 0, ptr = 0, state = ARB, owner = 0. in_ready is 0 for every channel during reset.
- Latency: a beat accepted at edge N is visible on out_* after edge N, and can be consumed in the same cycle that out_ready is high.
- Throughput: with out_ready tied high, one beat per clock.
- in_ready is combinational from in_valid, out_valid, out_ready, state and ptr. No output register depends combinationally on inputs.
- Inputs must hold valid/data/last stable until accepted (standard valid/ready). The block does not rely on this for correctness of its own state.
- Simultaneous accept and drain in the same cycle is legal and does not stall.
- rst asserted mid-packet: state returns to ARB, any held output beat is discarded, and out_valid = 0 on the next cycle. Upstream sees in_ready = 0 while rst is high.
- Pointer wrap: a grant to channel 3 sets ptr = 0.

## Test plan
- Reset: drive in_valid = 4'hF, out_ready = 1, rst = 1 for 3 cycles -> in_ready = 0 and out_valid = 0 throughout. The first beat after release comes from channel 0, with out_sel = 0.
- Round-robin fairness: all four channels send single-beat packets (in_last = 1) continuously, with data = 8'h10+i, and out_ready = 1. The expected order is:
  - out_sel sequence 0,1,2,3,0,1...
  - out_data sequence 8'h10, 8'h11, 8'h12, 8'h13, repeating
  - one beat per clock, no gaps.
- Packet lock: channel 2 sends a 3-beat packet (AA, AB, AC, last on AC) while channel 0 sends single beats. Output must be AA, AB, AC with out_sel = 2 contiguous, with in_ready[0] = 0 during the packet. Channel 0 follows next, since ptr = 3 wraps through 0.
- Backpressure: hold out_ready = 0 for 5 cycles with a beat held in the output register -> out_data/out_sel unchanged and in_ready = 0. Release -> the held beat is consumed and the next beat is loaded in the same cycle.
- Owner stall: channel 1 sends a first beat with in_last = 0, then drops in_valid for 4 cycles while channel 3 stays valid. Expected: no output from channel 3 during the stall, and channel 3 is granted only after channel 1's last beat.
- Mid-packet reset: pulse rst while in LOCK on channel 2 -> out_valid = 0 next cycle. The next grant follows ptr = 0 order, with channel 0 or the lowest valid index from 0 going first.
